// File: rtl/tx_engine.sv
// UART transmit engine: latches a byte on load and serializes an 11-bit
// frame (start, 7/8 data bits LSB-first, optional parity, stop bits) at the
// bit rate selected by a 4-bit baud code. tx_rdy flags when a new byte may be loaded.
module tx_engine #(
    parameter int CNT_W = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] d_in,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic [3:0] baud,
    output logic       tx,
    output logic       tx_rdy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Terminal value of the bit-time counter (clocks per bit minus one).
    function automatic logic [CNT_W-1:0] baud_limit(input logic [3:0] code);
        logic [CNT_W-1:0] lim;
        case (code)
            4'h0:    lim = CNT_W'(333332);
            4'h1:    lim = CNT_W'(83332);
            4'h2:    lim = CNT_W'(41666);
            4'h3:    lim = CNT_W'(20832);
            4'h4:    lim = CNT_W'(10416);
            4'h5:    lim = CNT_W'(5207);
            4'h6:    lim = CNT_W'(2603);
            4'h7:    lim = CNT_W'(1735);
            4'h8:    lim = CNT_W'(867);
            4'h9:    lim = CNT_W'(433);
            4'hA:    lim = CNT_W'(216);
            default: lim = CNT_W'(108);
        endcase
        return lim;
    endfunction

    state_t           state_q, state_d;
    logic [9:0]       sr_q, sr_d;        // frame bits still to send, b10..b1
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;      // bit-time limit frozen for the frame
    logic             tx_q, tx_d;
    logic             rdy_q, rdy_d;

    logic             parity;
    logic [1:0]       tail;              // {b9, b8}
    logic [10:0]      frame;

    // Assemble the frame from the live inputs; only used on an accepted load.
    always_comb begin
        parity = (eight ? (^d_in[7:0]) : (^d_in[6:0])) ^ ohel;
        case ({eight, pen})
            2'b00:   tail = {1'b1, 1'b1};
            2'b01:   tail = {1'b1, parity};
            2'b10:   tail = {1'b1, d_in[7]};
            default: tail = {parity, d_in[7]};
        endcase
        frame = {1'b1, tail, d_in[6:0], 1'b0};
    end

    // Next-state logic: accept a load in IDLE, then step one bit per bit-time.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        lim_d     = lim_q;
        tx_d      = tx_q;
        rdy_d     = rdy_q;
        case (state_q)
            IDLE: begin
                if (load && rdy_q) begin
                    sr_d      = frame[10:1];
                    tx_d      = frame[0];
                    lim_d     = baud_limit(baud);
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    rdy_d     = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == lim_q) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        // Last stop bit done: back to idle, line high, ready.
                        sr_d      = '1;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                        rdy_d     = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = sr_q[0];
                        sr_d      = {1'b1, sr_q[9:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '1;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            lim_q     <= '0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            tx_q      <= tx_d;
            rdy_q     <= rdy_d;
        end
    end

    assign tx     = tx_q;
    assign tx_rdy = rdy_q;

endmodule

// File: tb/tb_tx_engine.sv
// Testbench for tx_engine: table of frames plus hand-written sequences for
// ignored mid-frame loads, back-to-back loads and asynchronous reset.
module tb_tx_engine;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] d_in;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic [3:0] baud;
    logic       tx;
    logic       tx_rdy;

    int total;
    int bad;

    logic exp_q[$];

    typedef struct {
        logic [7:0]  d;
        logic        e;
        logic        p;
        logic        o;
        logic [3:0]  b;
        int          k;
        logic [10:0] f;   // expected b10..b0
    } vec_t;

    vec_t vecs[7];

    tx_engine #(.CNT_W(19)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .d_in   (d_in),
        .eight  (eight),
        .pen    (pen),
        .ohel   (ohel),
        .baud   (baud),
        .tx     (tx),
        .tx_rdy (tx_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle load and queue the frame bits it should produce.
    // Called 1 time unit after a rising edge; returns 1 unit after the load edge.
    task automatic start_load(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic [3:0] b, input logic [10:0] f);
        d_in  = d;
        eight = e;
        pen   = p;
        ohel  = o;
        baud  = b;
        load  = 1'b1;
        for (int i = 0; i <= 10; i++) exp_q.push_back(f[i]);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Check 11 bits of k clocks each against the queue; optionally inject a
    // mid-frame load with scrambled inputs at cycle inj.
    task automatic check_frame(input int k, input int inj, input int id);
        logic cur;
        logic bad_bit;
        logic seen_tx;
        logic seen_rdy;
        cur = 1'b1;
        bad_bit = 1'b0;
        seen_tx = 1'b0;
        seen_rdy = 1'b0;
        for (int c = 0; c < 11 * k; c++) begin
            if (c % k == 0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame%0d queue_empty bit%0d", id, c / k);
                    cur = 1'b1;
                end else begin
                    cur = exp_q.pop_front();
                end
                bad_bit = 1'b0;
            end
            if ((tx !== cur || tx_rdy !== 1'b0) && !bad_bit) begin
                bad_bit  = 1'b1;
                seen_tx  = tx;
                seen_rdy = tx_rdy;
            end
            if (c % k == k - 1) begin
                total++;
                if (bad_bit) begin
                    bad++;
                    $display("FAIL frame%0d bit%0d: got tx=%b rdy=%b want tx=%b rdy=0 (cycle %0d)",
                             id, c / k, seen_tx, seen_rdy, cur, c);
                end
            end
            if (c == inj) begin
                load  = 1'b1;
                d_in  = 8'hFF;
                eight = ~eight;
                pen   = ~pen;
                ohel  = ~ohel;
                baud  = 4'h0;
            end
            if (c == inj + 1) load = 1'b0;
            @(posedge clk);
            #1;
        end
        total++;
        if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
            bad++;
            $display("FAIL frame%0d end: got tx=%b rdy=%b want tx=1 rdy=1", id, tx, tx_rdy);
        end
        $display("frame%0d checked, running total=%0d bad=%0d", id, total, bad);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        load  = 1'b0;
        d_in  = 8'h00;
        eight = 1'b0;
        pen   = 1'b0;
        ohel  = 1'b0;
        baud  = 4'hB;

        //            d      e     p     o     baud  k    frame b10..b0
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 4'hB, 109, 11'h4AA};
        vecs[1] = '{8'h55, 1'b1, 1'b1, 1'b1, 4'hB, 109, 11'h6AA};
        vecs[2] = '{8'hC1, 1'b0, 1'b0, 1'b0, 4'hB, 109, 11'h782};
        vecs[3] = '{8'h07, 1'b0, 1'b1, 1'b0, 4'hB, 109, 11'h70E};
        vecs[4] = '{8'hA3, 1'b1, 1'b1, 1'b1, 4'hF, 109, 11'h746};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b1, 4'hA, 217, 11'h778};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 4'h8, 868, 11'h400};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got tx=%b rdy=%b want tx=1 rdy=1", tx, tx_rdy);
        end
        reset = 1'b0;
        idle_cycles(3);
        total++;
        if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: got tx=%b rdy=%b want tx=1 rdy=1", tx, tx_rdy);
        end

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            start_load(vecs[v].d, vecs[v].e, vecs[v].p, vecs[v].o, vecs[v].b, vecs[v].f);
            check_frame(vecs[v].k, -1, v);
            idle_cycles(3);
        end

        // Mid-frame load ignored, then reload on the cycle tx_rdy rises
        start_load(8'h55, 1'b1, 1'b1, 1'b0, 4'hB, 11'h4AA);
        check_frame(109, 300, 10);
        start_load(8'h0F, 1'b1, 1'b0, 1'b0, 4'hB, 11'h61E);
        check_frame(109, -1, 11);
        idle_cycles(2);

        // Asynchronous reset during bit 4 (a low data bit)
        start_load(8'h07, 1'b0, 1'b1, 1'b0, 4'hB, 11'h70E);
        idle_cycles(4 * 109 + 50);
        total++;
        if (tx !== 1'b0 || tx_rdy !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_bit4: got tx=%b rdy=%b want tx=0 rdy=0", tx, tx_rdy);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got tx=%b rdy=%b want tx=1 rdy=1", tx, tx_rdy);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        begin
            logic hold_bad;
            logic got_tx;
            logic got_rdy;
            hold_bad = 1'b0;
            got_tx = 1'b1;
            got_rdy = 1'b1;
            for (int c = 0; c < 12 * 109; c++) begin
                if ((tx !== 1'b1 || tx_rdy !== 1'b1) && !hold_bad) begin
                    hold_bad = 1'b1;
                    got_tx = tx;
                    got_rdy = tx_rdy;
                end
                @(posedge clk);
                #1;
            end
            total++;
            if (hold_bad) begin
                bad++;
                $display("FAIL no_resume_after_reset: got tx=%b rdy=%b want tx=1 rdy=1",
                         got_tx, got_rdy);
            end
            $display("post-reset idle hold checked, running total=%0d bad=%0d", total, bad);
        end

        // Engine usable again after reset
        start_load(8'hC1, 1'b0, 1'b0, 1'b0, 4'hB, 11'h782);
        check_frame(109, -1, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_engine.md
Name: tx_engine

Overview:
- UART transmit engine of the TramelBlaze UART; the counterpart of the receive engine and its remapping stage.
- Accepts a byte from the processor output port on a load strobe and serializes it onto the Tx line as one 11-bit frame: start bit, 7 or 8 data bits LSB-first, optional parity, stop bit(s).
- Frame format is selected by eight/pen/ohel, using the same field convention as the receive side.
- Bit rate is selected by a 4-bit baud code; tx_rdy is the status flag and interrupt source for the processor.

Parameters:
- CNT_W, 19, width of the bit-time counter; must hold the largest baud count (333333).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle write strobe from the processor port decode.
- d_in  input  8  byte to transmit; sampled on the load cycle.
- eight  input  1  1 = 8 data bits, 0 = 7 data bits.
- pen  input  1  parity enable.
- ohel  input  1  parity sense: 0 = even, 1 = odd.
- baud  input  4  bit-rate select.
- tx  output  1  serial line, idle high.
- tx_rdy  output  1  high when the engine can accept a new load.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - tx=1, tx_rdy=1, shift register all ones, counters 0, busy=0.
  - The frame in progress is abandoned with no glitch low.
- Baud table, clocks per bit K (100 MHz / rate):
  - 0:333333 (300), 1:83333 (1200), 2:41667 (2400), 3:20833 (4800), 4:10417 (9600), 5:5208 (19200).
  - 6:2604 (38400), 7:1736 (57600), 8:868 (115200), 9:434 (230400), A:217 (460800), B:109 (921600).
  - C–F: 109.
  - baud is sampled on the load cycle and held for the whole frame.
- Parity p:
  - 7-bit mode: p = ^d_in[6:0]; 8-bit mode: p = ^d_in[7:0].
  - If ohel=1, p is inverted (odd parity).
- Frame bits b10..b0, shifted LSB-first, 11 bits always:
  - b0 = 0 (start); b7..b1 = d_in[6:0]; b10 = 1.
  - {b9,b8} by {eight,pen}:
    - 00 -> {1,1}
    - 01 -> {1,p}
    - 10 -> {1,d_in[7]}
    - 11 -> {p,d_in[7]}
  - Unused trailing positions are therefore extra stop bits.
- Load acceptance (cycle N):
  - Accepted only if tx_rdy=1.
  - Data, config and baud are latched into the shift register at edge N.
  - tx_rdy=0 from cycle N+1; busy=1.
- Load while tx_rdy=0 is ignored entirely: no data change, no restart.
- Transmit timing:
  - tx is registered; tx=b0=0 from cycle N+1.
  - Each bit lasts exactly K clocks; the bit counter advances when the bit-time counter reaches K-1, then the counter returns to 0.
  - Bit i occupies cycles N+1+i·K through N+(i+1)·K.
- Completion:
  - After bit 10 finishes (cycle N+11·K), tx returns/stays 1, busy=0, and tx_rdy=1 from cycle N+11·K+1.
  - A new load is accepted on that same cycle.
- States: IDLE (tx=1, tx_rdy=1) -> SHIFT (11 bits) -> IDLE. No other states.
- d_in, eight, pen, ohel and baud changing mid-frame must not affect the frame in flight.

Test Plan:
- Reset asserted mid-frame at bit 4 -> tx=1 and tx_rdy=1 within the same cycle (async); after release, no frame resumes and tx stays 1.
- baud=B, eight=1, pen=1, ohel=0, load d_in=0x55 -> each bit 109 clocks, tx sequence 0,1,0,1,0,1,0,1,0,0(p),1; tx_rdy low for exactly 1199 cycles, then high.
- Same stimulus with ohel=1 -> parity bit = 1; all other bits unchanged.
- eight=0, pen=0, d_in=0xC1 -> sequence 0,1,0,0,0,0,0,1,1,1,1; d_in[7] is never transmitted.
- eight=0, pen=1, ohel=0, d_in=0x07 -> sequence 0,1,1,1,0,0,0,0,1(p),1,1.
- Load pulsed mid-frame with 0xFF, then again on the cycle tx_rdy rises with 0x0F -> first frame unaltered; second frame starts the cycle after the second load with back-to-back timing and no idle gap beyond one cycle.
